// File: rtl/uart_rx_ctrl.sv
// UART receive controller: qualifies the start bit, majority-votes each bit from
// three mid-bit samples, and checks parity/stop against the deserializer's word.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int EDGE_CNT_WIDTH = 3,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  output logic [EDGE_CNT_WIDTH-1:0] edge_cnt,
  output logic                      sampled_bit,
  output logic                      deser_en,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int OS = 1 << EDGE_CNT_WIDTH;
  localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_ONE  = EDGE_CNT_WIDTH'(1);
  localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_SMP0 = EDGE_CNT_WIDTH'(OS / 2 - 1);
  localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_SMP1 = EDGE_CNT_WIDTH'(OS / 2);
  localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_SMP2 = EDGE_CNT_WIDTH'(OS / 2 + 1);
  localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_LAST = EDGE_CNT_WIDTH'(OS - 1);
  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_LAST  = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [EDGE_CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic                      rx_q, rx_d;
  logic [1:0]                smp_q, smp_d;
  logic                      sampled_bit_q, sampled_bit_d;
  logic                      deser_en_q, deser_en_d;
  logic                      data_valid_q, data_valid_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;

  logic bit_end;
  logic start_edge;
  logic par_exp;

  assign bit_end    = (edge_cnt_q == EDGE_LAST);
  assign start_edge = rx_q & ~RX_IN;
  assign par_exp    = (^P_DATA) ^ par_typ_q;

  always_comb begin
    state_d       = state_q;
    edge_cnt_d    = edge_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = RX_IN;
    smp_d         = smp_q;
    sampled_bit_d = sampled_bit_q;
    data_valid_d  = 1'b0;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;

    // Three samples straddle mid-bit; the vote lands two edges before bit end.
    if (state_q != S_IDLE) begin
      edge_cnt_d = edge_cnt_q + EDGE_ONE;
      if (edge_cnt_q == EDGE_SMP0) smp_d[0] = RX_IN;
      if (edge_cnt_q == EDGE_SMP1) smp_d[1] = RX_IN;
      if (edge_cnt_q == EDGE_SMP2)
        sampled_bit_d = (smp_q[0] & smp_q[1]) | (smp_q[0] & RX_IN) | (smp_q[1] & RX_IN);
    end

    case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        par_en_d   = PAR_EN;
        par_typ_d  = PAR_TYP;
        if (start_edge) begin
          state_d    = S_START;
          edge_cnt_d = EDGE_ONE;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          if (!sampled_bit_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          par_err_d = (sampled_bit_q != par_exp);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          stp_err_d    = ~sampled_bit_q;
          data_valid_d = sampled_bit_q & ~par_err_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    deser_en_d = (state_d == S_DATA);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      edge_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      rx_q          <= 1'b1;
      smp_q         <= 2'b11;
      sampled_bit_q <= 1'b1;
      deser_en_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      smp_q         <= smp_d;
      sampled_bit_q <= sampled_bit_d;
      deser_en_q    <= deser_en_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
    end
  end

  assign edge_cnt    = edge_cnt_q;
  assign sampled_bit = sampled_bit_q;
  assign deser_en    = deser_en_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: per-cycle line waveforms, a small deserializer, and a
// frame-level reference model for valid/parity/stop outcomes.
module tb_uart_rx_ctrl;
  localparam int OS = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic [2:0] edge_cnt;
  logic       sampled_bit, deser_en, data_valid, par_err, stp_err;

  uart_rx_ctrl #(.DATA_WIDTH(8), .EDGE_CNT_WIDTH(3), .BIT_CNT_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .edge_cnt(edge_cnt), .sampled_bit(sampled_bit),
    .deser_en(deser_en), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  // Each entry is one clock cycle of stimulus: {rx, par_en, par_typ}.
  logic [2:0] line_q[$];
  logic       obs_dv[$], obs_pe[$], obs_se[$], obs_de[$], obs_sb[$];
  logic [2:0] obs_ec[$];
  logic [7:0] obs_pd[$];

  task automatic push_cycles(input int n, input logic rx, input logic pen, input logic ptyp);
    repeat (n) line_q.push_back({rx, pen, ptyp});
  endtask

  task automatic add_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic pbit, input logic stop, output int start);
    start = line_q.size();
    push_cycles(OS, 1'b0, pen, ptyp);
    for (int b = 0; b < 8; b++) push_cycles(OS, d[b], pen, ptyp);
    if (pen) push_cycles(OS, pbit, pen, ptyp);
    push_cycles(OS, stop, pen, ptyp);
  endtask

  // Plays the line, records outputs mid-cycle, and acts as the LSB-first deserializer.
  task automatic run_line(input int limit);
    obs_dv.delete(); obs_pe.delete(); obs_se.delete(); obs_de.delete();
    obs_sb.delete(); obs_ec.delete(); obs_pd.delete();
    for (int k = 0; k < line_q.size() && k < limit; k++) begin
      {RX_IN, PAR_EN, PAR_TYP} = line_q[k];
      @(negedge CLK);
      obs_dv.push_back(data_valid);
      obs_pe.push_back(par_err);
      obs_se.push_back(stp_err);
      obs_de.push_back(deser_en);
      obs_sb.push_back(sampled_bit);
      obs_ec.push_back(edge_cnt);
      obs_pd.push_back(P_DATA);
      if (deser_en && edge_cnt == 3'd7) P_DATA = {sampled_bit, P_DATA[7:1]};
      @(posedge CLK);
      #1;
    end
  endtask

  // Frame-level model: parity counts ones over data+parity bit.
  function automatic logic model_par_err(input logic [7:0] d, input logic pen,
                                         input logic ptyp, input logic pbit);
    if (!pen) return 1'b0;
    return ((($countones(d) + int'(pbit)) % 2) != int'(ptyp));
  endfunction

  function automatic logic good_parity(input logic [7:0] d, input logic ptyp);
    return 1'(($countones(d) + int'(ptyp)) % 2);
  endfunction

  task automatic test_reset();
    nvec++; if (edge_cnt !== 3'd0) begin nerr++; $display("FAIL reset_edge_cnt: got %0d, want 0", edge_cnt); end
    nvec++; if (sampled_bit !== 1'b1) begin nerr++; $display("FAIL reset_sampled_bit: got %b, want 1", sampled_bit); end
    nvec++; if (deser_en !== 1'b0) begin nerr++; $display("FAIL reset_deser_en: got %b, want 0", deser_en); end
    nvec++; if (data_valid !== 1'b0) begin nerr++; $display("FAIL reset_data_valid: got %b, want 0", data_valid); end
    nvec++; if (par_err !== 1'b0) begin nerr++; $display("FAIL reset_par_err: got %b, want 0", par_err); end
    nvec++; if (stp_err !== 1'b0) begin nerr++; $display("FAIL reset_stp_err: got %b, want 0", stp_err); end
  endtask

  task automatic test_8n1();
    int s, n, ndv;
    logic [7:0] d;
    d = 8'hA5;
    line_q.delete();
    push_cycles(4, 1'b1, 1'b0, 1'b0);
    add_frame(d, 1'b0, 1'b0, 1'b0, 1'b1, s);
    push_cycles(8, 1'b1, 1'b0, 1'b0);
    run_line(line_q.size());
    n = 0; ndv = 0;
    foreach (obs_de[i]) begin
      if (obs_de[i]) n++;
      if (obs_dv[i]) ndv++;
    end
    nvec++; if (n != 64) begin nerr++; $display("FAIL 8n1_deser_cycles: got %0d, want 64", n); end
    nvec++; if (obs_de[s+7] !== 1'b0 || obs_de[s+8] !== 1'b1 || obs_de[s+71] !== 1'b1 || obs_de[s+72] !== 1'b0) begin
      nerr++; $display("FAIL 8n1_deser_window: got %b%b%b%b at +7/+8/+71/+72, want 0110",
                       obs_de[s+7], obs_de[s+8], obs_de[s+71], obs_de[s+72]);
    end
    nvec++; if (ndv != 1) begin nerr++; $display("FAIL 8n1_dv_count: got %0d, want 1", ndv); end
    nvec++; if (obs_dv[s+80] !== 1'b1) begin nerr++; $display("FAIL 8n1_dv_cycle80: got %b, want 1", obs_dv[s+80]); end
    nvec++; if (obs_pd[s+80] !== d) begin nerr++; $display("FAIL 8n1_p_data: got %h, want %h", obs_pd[s+80], d); end
    nvec++; if (obs_pe[s+80] !== 1'b0 || obs_se[s+80] !== 1'b0) begin
      nerr++; $display("FAIL 8n1_flags: got pe=%b se=%b, want 0 0", obs_pe[s+80], obs_se[s+80]);
    end
    nvec++; if (obs_ec[s] !== 3'd0 || obs_ec[s+1] !== 3'd1 || obs_ec[s+7] !== 3'd7 || obs_ec[s+8] !== 3'd0) begin
      nerr++; $display("FAIL 8n1_edge_cnt: got %0d %0d %0d %0d, want 0 1 7 0",
                       obs_ec[s], obs_ec[s+1], obs_ec[s+7], obs_ec[s+8]);
    end
    for (int b = 0; b < 8; b++) begin
      nvec++;
      if (obs_sb[s + OS*(b+1) + OS-1] !== d[b]) begin
        nerr++; $display("FAIL 8n1_sampled_bit%0d: got %b, want %b", b, obs_sb[s + OS*(b+1) + OS-1], d[b]);
      end
    end
  endtask

  task automatic test_8e1();
    int s1, s2, s3, ndv;
    line_q.delete();
    push_cycles(4, 1'b1, 1'b1, 1'b0);
    add_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, s1);
    push_cycles(6, 1'b1, 1'b1, 1'b0);
    add_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, s2);
    push_cycles(20, 1'b1, 1'b1, 1'b0);
    add_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, s3);
    push_cycles(8, 1'b1, 1'b1, 1'b0);
    run_line(line_q.size());
    ndv = 0; foreach (obs_dv[i]) if (obs_dv[i]) ndv++;
    nvec++; if (obs_dv[s1+80] !== 1'b0 || obs_dv[s1+88] !== 1'b1) begin
      nerr++; $display("FAIL 8e1_dv_cycle88: got %b at 80, %b at 88, want 0 1", obs_dv[s1+80], obs_dv[s1+88]);
    end
    nvec++; if (obs_pd[s1+88] !== 8'h03) begin nerr++; $display("FAIL 8e1_p_data: got %h, want 03", obs_pd[s1+88]); end
    nvec++; if (obs_pe[s2+88] !== 1'b1 || obs_dv[s2+88] !== 1'b0) begin
      nerr++; $display("FAIL 8e1_par_err: got pe=%b dv=%b, want 1 0", obs_pe[s2+88], obs_dv[s2+88]);
    end
    nvec++; if (obs_pe[s3] !== 1'b1 || obs_pe[s3+1] !== 1'b0) begin
      nerr++; $display("FAIL 8e1_par_err_sticky: got %b before start, %b after, want 1 0", obs_pe[s3], obs_pe[s3+1]);
    end
    nvec++; if (ndv != 2 || obs_dv[s3+88] !== 1'b1) begin
      nerr++; $display("FAIL 8e1_dv_total: got %0d pulses (last frame %b), want 2 (1)", ndv, obs_dv[s3+88]);
    end
  endtask

  task automatic test_stop_err();
    int s1, s2, ndv, nbusy;
    line_q.delete();
    push_cycles(4, 1'b1, 1'b0, 1'b0);
    add_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, s1);
    push_cycles(30, 1'b0, 1'b0, 1'b0);
    push_cycles(5, 1'b1, 1'b0, 1'b0);
    add_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, s2);
    push_cycles(8, 1'b1, 1'b0, 1'b0);
    run_line(line_q.size());
    ndv = 0; foreach (obs_dv[i]) if (obs_dv[i]) ndv++;
    nbusy = 0;
    for (int k = s1 + 80; k <= s2; k++) if (obs_ec[k] !== 3'd0 || obs_de[k] !== 1'b0) nbusy++;
    nvec++; if (obs_se[s1+80] !== 1'b1 || obs_dv[s1+80] !== 1'b0) begin
      nerr++; $display("FAIL stop_err_flag: got se=%b dv=%b, want 1 0", obs_se[s1+80], obs_dv[s1+80]);
    end
    nvec++; if (nbusy != 0) begin nerr++; $display("FAIL stop_low_line_idle: got %0d busy cycles, want 0", nbusy); end
    nvec++; if (obs_se[s2] !== 1'b1 || obs_se[s2+1] !== 1'b0) begin
      nerr++; $display("FAIL stop_err_sticky: got %b before start, %b after, want 1 0", obs_se[s2], obs_se[s2+1]);
    end
    nvec++; if (ndv != 1 || obs_dv[s2+80] !== 1'b1 || obs_pd[s2+80] !== 8'h3C) begin
      nerr++; $display("FAIL stop_err_next_frame: got %0d pulses, dv=%b data=%h, want 1 1 3c",
                       ndv, obs_dv[s2+80], obs_pd[s2+80]);
    end
  endtask

  task automatic test_glitch();
    int s, nact;
    line_q.delete();
    push_cycles(4, 1'b1, 1'b0, 1'b0);
    s = line_q.size();
    push_cycles(2, 1'b0, 1'b0, 1'b0);
    push_cycles(20, 1'b1, 1'b0, 1'b0);
    run_line(line_q.size());
    nact = 0;
    foreach (obs_de[i]) if (obs_de[i] || obs_dv[i] || obs_pe[i] || obs_se[i]) nact++;
    nvec++; if (obs_ec[s+1] !== 3'd1 || obs_ec[s+7] !== 3'd7 || obs_ec[s+8] !== 3'd0 || obs_ec[s+12] !== 3'd0) begin
      nerr++; $display("FAIL glitch_return_idle: got edge_cnt %0d %0d %0d %0d, want 1 7 0 0",
                       obs_ec[s+1], obs_ec[s+7], obs_ec[s+8], obs_ec[s+12]);
    end
    nvec++; if (nact != 0) begin nerr++; $display("FAIL glitch_no_activity: got %0d active cycles, want 0", nact); end
  endtask

  task automatic test_noise();
    int s1, s2;
    logic [2:0] e;
    line_q.delete();
    push_cycles(4, 1'b1, 1'b0, 1'b0);
    add_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, s1);
    push_cycles(3, 1'b1, 1'b0, 1'b0);
    add_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, s2);
    push_cycles(8, 1'b1, 1'b0, 1'b0);
    for (int b = 1; b <= 8; b++) begin
      e = line_q[s1 + OS*b + 4]; e[2] = ~e[2]; line_q[s1 + OS*b + 4] = e;
      e = line_q[s2 + OS*b + 4]; e[2] = ~e[2]; line_q[s2 + OS*b + 4] = e;
    end
    run_line(line_q.size());
    nvec++; if (obs_dv[s1+80] !== 1'b1 || obs_pd[s1+80] !== 8'hFF) begin
      nerr++; $display("FAIL noise_ff: got dv=%b data=%h, want 1 ff", obs_dv[s1+80], obs_pd[s1+80]);
    end
    nvec++; if (obs_dv[s2+80] !== 1'b1 || obs_pd[s2+80] !== 8'h00) begin
      nerr++; $display("FAIL noise_00: got dv=%b data=%h, want 1 00", obs_dv[s2+80], obs_pd[s2+80]);
    end
  endtask

  task automatic test_reset_mid();
    int s, ndv;
    line_q.delete();
    push_cycles(4, 1'b1, 1'b0, 1'b0);
    add_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, s);
    run_line(s + 40);
    nvec++; if (deser_en !== 1'b1) begin nerr++; $display("FAIL rst_mid_precondition: got deser_en=%b, want 1", deser_en); end
    RST = 1'b1;
    #1;
    test_reset();
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    RST = 1'b0;
    line_q.delete();
    push_cycles(4, 1'b1, 1'b0, 1'b0);
    add_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, s);
    push_cycles(8, 1'b1, 1'b0, 1'b0);
    run_line(line_q.size());
    ndv = 0; foreach (obs_dv[i]) if (obs_dv[i]) ndv++;
    nvec++; if (ndv != 1 || obs_dv[s+80] !== 1'b1 || obs_pd[s+80] !== 8'h81) begin
      nerr++; $display("FAIL rst_mid_next_frame: got %0d pulses, dv=%b data=%h, want 1 1 81",
                       ndv, obs_dv[s+80], obs_pd[s+80]);
    end
  endtask

  // Random frames with 0..4 idle cycles between them, including true back-to-back.
  task automatic test_back_to_back();
    int         starts[$], lens[$];
    logic [7:0] ds[$];
    logic       ev[$], epe[$], ese[$];
    logic       prev_stop;
    int         ndv, nexp, nboth, k;
    prev_stop = 1'b1;
    line_q.delete();
    push_cycles(4, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 40; f++) begin
      logic [7:0] d;
      logic       pen, ptyp, pbit, stop, pe;
      int         s, gap;
      d    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      pbit = good_parity(d, ptyp) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 6) != 0);
      gap  = prev_stop ? $urandom_range(0, 3) : $urandom_range(1, 4);
      push_cycles(gap, 1'b1, pen, ptyp);
      add_frame(d, pen, ptyp, pbit, stop, s);
      pe = model_par_err(d, pen, ptyp, pbit);
      starts.push_back(s);
      lens.push_back((10 + int'(pen)) * OS);
      ds.push_back(d);
      epe.push_back(pe);
      ese.push_back(~stop);
      ev.push_back(~pe & stop);
      prev_stop = stop;
    end
    push_cycles(8, 1'b1, 1'b0, 1'b0);
    run_line(line_q.size());
    for (int f = 0; f < 40; f++) begin
      k = starts[f] + lens[f];
      nvec++; if (obs_dv[k] !== ev[f]) begin
        nerr++; $display("FAIL b2b_dv[%0d]: got %b, want %b", f, obs_dv[k], ev[f]);
      end
      nvec++; if (obs_pe[k] !== epe[f] || obs_se[k] !== ese[f]) begin
        nerr++; $display("FAIL b2b_flags[%0d]: got pe=%b se=%b, want %b %b", f, obs_pe[k], obs_se[k], epe[f], ese[f]);
      end
      if (ev[f]) begin
        nvec++; if (obs_pd[k] !== ds[f]) begin
          nerr++; $display("FAIL b2b_data[%0d]: got %h, want %h", f, obs_pd[k], ds[f]);
        end
      end
    end
    ndv = 0; nexp = 0; nboth = 0;
    foreach (obs_dv[i]) begin
      if (obs_dv[i]) ndv++;
      if (obs_dv[i] && (obs_pe[i] || obs_se[i])) nboth++;
    end
    foreach (ev[i]) if (ev[i]) nexp++;
    nvec++; if (ndv != nexp) begin nerr++; $display("FAIL b2b_dv_total: got %0d, want %0d", ndv, nexp); end
    nvec++; if (nboth != 0) begin nerr++; $display("FAIL b2b_exclusive: got %0d cycles with dv and error, want 0", nboth); end
  endtask

  initial begin
    #2;
    RST = 1'b1;
    #1;
    test_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    test_8n1();
    test_8e1();
    test_stop_err();
    test_glitch();
    test_noise();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller of the UART RX path. It oversamples the serial line and detects and qualifies the start bit. It produces the per-bit `edge_cnt`, majority-voted `sampled_bit` and `deser_en` strobes consumed by the RX deserializer. It checks the parity and stop bits against the deserializer's `P_DATA` and flags each completed frame with a single-cycle `data_valid` or a sticky error.

## Interface

Parameters:
- `DATA_WIDTH`, 8, data bits per frame (LSB first on the line).
- `EDGE_CNT_WIDTH`, 3, oversampling counter width; oversampling ratio OS = 2^EDGE_CNT_WIDTH (8 by default).
- `BIT_CNT_WIDTH`, 4, width of the internal data-bit counter; must satisfy 2^BIT_CNT_WIDTH > DATA_WIDTH.

Ports:
- `CLK`  in  1  oversampling clock, OS cycles per bit period.
- `RST`  in  1  asynchronous, active-high reset.
- `RX_IN`  in  1  serial line, already synchronized, idle high.
- `PAR_EN`  in  1  1 = frame carries a parity bit.
- `PAR_TYP`  in  1  0 = even, 1 = odd parity.
- `P_DATA`  in  DATA_WIDTH  parallel word from the deserializer.
- `edge_cnt`  out  EDGE_CNT_WIDTH  oversample index within the current bit.
- `sampled_bit`  out  1  majority-voted value of the current bit.
- `deser_en`  out  1  high while data bits are being received.
- `data_valid`  out  1  one-cycle pulse: `P_DATA` holds a good frame.
- `par_err`  out  1  parity mismatch on last frame (sticky until next start).
- `stp_err`  out  1  stop bit sampled low on last frame (sticky until next start).

## Operation

- Reset values:
  - state IDLE; `edge_cnt`=0, `sampled_bit`=1, `deser_en`=0, `data_valid`=0, `par_err`=0, `stp_err`=0.
  - Internal `rx_q`=1; bit counter=0.
- `rx_q` registers `RX_IN` every cycle. A start is detected only on a falling edge, i.e. `rx_q`=1 and `RX_IN`=0 while in IDLE. A line held low never re-triggers.
- Counters:
  - `edge_cnt` is held 0 in IDLE. It increments every cycle in all other states and wraps OS-1 → 0.
  - "Bit end" means a cycle with `edge_cnt`=OS-1.
- Sampling:
  - `RX_IN` is captured at edges OS/2-1, OS/2, OS/2+1 (3, 4, 5 by default).
  - At edge OS/2+1, `sampled_bit` registers the majority of the three samples and holds until the next bit's update.
- States:
  - IDLE:
    - Falling edge → START, `edge_cnt`←1; the detection cycle is edge 0.
    - `PAR_EN`/`PAR_TYP` are latched here and used for the whole frame.
    - `par_err` and `stp_err` are cleared.
  - START:
    - At bit end, `sampled_bit`=0 → DATA with bit counter 0.
    - At bit end, `sampled_bit`=1 → IDLE (glitch rejected, no flags).
  - DATA:
    - `deser_en`=1 for every cycle in this state.
    - At bit end, the bit counter increments.
    - At bit end with counter = DATA_WIDTH-1 → PARITY if latched `PAR_EN`, else STOP.
  - PARITY:
    - At bit end, expected = XOR-reduce(`P_DATA`) XOR latched `PAR_TYP`.
    - `par_err` ← (`sampled_bit` ≠ expected). Then → STOP.
  - STOP:
    - At bit end, `stp_err` ← ~`sampled_bit`.
    - `data_valid` ← 1 if neither the new `stp_err` nor `par_err` is set.
    - Then → IDLE.
- `data_valid` is cleared the following cycle.
- `P_DATA` is not modified by this block. It is stable from the last data bit end onward, until the next frame's DATA state.
- Reset asserted mid-frame: immediate return to reset values. No `data_valid` is issued for the aborted frame.

## Timing

- Frame length F = 1 + DATA_WIDTH + `PAR_EN` + 1 bits; F×OS cycles.
- Counting the start-detection cycle as cycle 0, `data_valid`, `par_err` and `stp_err` update on cycle F×OS.
  - 8N1: cycle 80.
  - 8E1: cycle 88.
- `deser_en` is high for exactly DATA_WIDTH×OS cycles.
  - It is high at each data-bit end, where `sampled_bit` already holds that bit's vote (updated at edge OS/2+1).
- Back-to-back frames: IDLE is re-entered on cycle F×OS.
  - A falling edge seen in that cycle starts the next frame with no lost bit.
- Errors and `data_valid` are mutually exclusive in the same cycle.

## Test plan

- 8N1, byte 0xA5 sent LSB first at OS=8 → `deser_en` high for 64 cycles; `data_valid` one pulse on cycle 80; `P_DATA`=0xA5; `par_err`=`stp_err`=0.
- 8E1, byte 0x03 with parity bit 0 → `data_valid` on cycle 88. Repeat with parity bit 1 → `par_err`=1, no `data_valid`, `par_err` held until next start.
- Stop bit driven low, 0x5A, 8N1 → `stp_err`=1 on cycle 80, no `data_valid`. Line held low afterward → stays IDLE until `RX_IN` returns high, then falls again.
- Start glitch: `RX_IN` low for 2 cycles only → return to IDLE after 8 cycles; `deser_en` never asserted; no flags.
- Single-sample noise: one cycle of inverted `RX_IN` at edge 4 of a data bit → majority vote still yields the correct bit; frame 0xFF received cleanly.
- `RST` pulsed high on cycle 40 of a frame → all outputs at reset values immediately; the next full frame 0x81 is received correctly.
